// File: rtl/set_job_sequencer.sv
// set_job_sequencer
//   Command front-end and result collector for the SET circle-candidate
//   engine. Jobs are buffered in a small FIFO. They are launched one at a
//   time with a single-cycle set_en pulse. Each candidate count is returned
//   with its job tag over a valid/ready result port. A watchdog aborts a job
//   whose engine never answers.
//
// Optional build macro: SET_JOB_STATS_EN enables the saturating
//   stat_jobs / stat_tmo counters. When it is undefined, both ports read 0.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (cmd_ready == !full)
//   cmd_central/radius/mode  SET job parameters
//   cmd_tag                  job identifier returned with the result
//   set_en                   one-cycle job start to SET
//   set_central/radius/mode  registered job parameters to SET
//   set_busy/valid/candidate SET status and result
//   res_valid/res_ready      result handshake
//   res_candidate/tag/err    result payload (err = aborted by watchdog)
//   pending                  FIFO occupancy
//   stat_jobs, stat_tmo      completed / timed-out job counters
module set_job_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 127
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [23:0]              cmd_central,
  input  logic [11:0]              cmd_radius,
  input  logic [1:0]               cmd_mode,
  input  logic [TAG_W-1:0]         cmd_tag,
  output logic                     set_en,
  output logic [23:0]              set_central,
  output logic [11:0]              set_radius,
  output logic [1:0]               set_mode,
  input  logic                     set_busy,
  input  logic                     set_valid,
  input  logic [7:0]               set_candidate,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               res_candidate,
  output logic [TAG_W-1:0]         res_tag,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [15:0]              stat_jobs,
  output logic [7:0]               stat_tmo
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [23:0]      central;
    logic [11:0]      radius;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_state, w_state_nxt;
  cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [TAG_W-1:0] r_tag;
  logic [WD_W-1:0]  r_wd;

  logic w_full, w_empty, w_push, w_pop, w_wd_hit, w_hs;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign w_push   = cmd_valid & ~w_full;
  assign w_pop    = (r_state == S_IDLE) & ~w_empty & ~set_busy;
  // The watchdog increments once per WAIT cycle. This is its last WAIT
  // cycle, so the register reaches TIMEOUT at this edge.
  assign w_wd_hit = (r_wd == WD_W'(TIMEOUT - 1));
  assign w_hs     = res_valid & res_ready;

  assign cmd_ready = ~w_full;
  assign pending   = r_count;
  assign set_en    = (r_state == S_ISSUE);
  assign res_valid = (r_state == S_RESP);
  assign res_tag   = r_tag;

  // NOTE: the storage array has no reset; r_count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{cmd_central, cmd_radius, cmd_mode, cmd_tag};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the next-state value is given a default first, so every path assigns it and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty && !set_busy) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (set_valid || w_wd_hit) w_state_nxt = S_RESP;
      S_RESP:  if (res_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_central   <= '0;
      set_radius    <= '0;
      set_mode      <= '0;
      r_tag         <= '0;
      r_wd          <= '0;
      res_candidate <= '0;
      res_err       <= 1'b0;
    end else begin
      if (w_pop) begin
        set_central <= r_mem[r_rd_ptr].central;
        set_radius  <= r_mem[r_rd_ptr].radius;
        set_mode    <= r_mem[r_rd_ptr].mode;
        r_tag       <= r_mem[r_rd_ptr].tag;
      end
      if (r_state == S_ISSUE) r_wd <= '0;
      else if (r_state == S_WAIT) r_wd <= r_wd + 1'b1;
      // A result that arrives in the watchdog's final cycle still counts as a success.
      if (r_state == S_WAIT) begin
        if (set_valid) begin
          res_candidate <= set_candidate;
          res_err       <= 1'b0;
        end else if (w_wd_hit) begin
          res_candidate <= '0;
          res_err       <= 1'b1;
        end
      end
    end
  end

`ifdef SET_JOB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_jobs <= '0;
      stat_tmo  <= '0;
    end else if (w_hs) begin
      if (!res_err && stat_jobs != 16'hFFFF) stat_jobs <= stat_jobs + 1'b1;
      if (res_err && stat_tmo != 8'hFF)      stat_tmo  <= stat_tmo + 1'b1;
    end
  end
`else
  assign stat_jobs = '0;
  assign stat_tmo  = '0;
  logic w_unused_hs;
  assign w_unused_hs = w_hs;
`endif

endmodule

// File: tb/tb_set_job_sequencer.sv
// Self-checking bench for set_job_sequencer. A SET stub answers each
// set_en after stub_lat cycles. Stimulus pushes the expected issue and
// result records into queues, and a monitor compares them at every set_en
// and at every result handshake.
module tb_set_job_sequencer;
  localparam int DEPTH = 4, TAG_W = 4, TIMEOUT = 127;

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, set_en, set_busy, set_valid;
  logic res_valid, res_ready, res_err;
  logic [23:0] cmd_central, set_central;
  logic [11:0] cmd_radius, set_radius;
  logic [1:0]  cmd_mode, set_mode;
  logic [TAG_W-1:0] cmd_tag, res_tag;
  logic [7:0]  set_candidate, res_candidate, stat_tmo;
  logic [$clog2(DEPTH):0] pending;
  logic [15:0] stat_jobs;

  always #5 clk = ~clk;

  set_job_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_central(cmd_central), .cmd_radius(cmd_radius), .cmd_mode(cmd_mode),
    .cmd_tag(cmd_tag), .set_en(set_en), .set_central(set_central),
    .set_radius(set_radius), .set_mode(set_mode), .set_busy(set_busy),
    .set_valid(set_valid), .set_candidate(set_candidate), .res_valid(res_valid),
    .res_ready(res_ready), .res_candidate(res_candidate), .res_tag(res_tag),
    .res_err(res_err), .pending(pending), .stat_jobs(stat_jobs), .stat_tmo(stat_tmo)
  );

  typedef struct packed {logic [23:0] c; logic [11:0] r; logic [1:0] m;} iss_t;
  typedef struct packed {logic [7:0] cand; logic [TAG_W-1:0] tag; logic err;} res_t;

  iss_t       exp_iss_q[$];
  res_t       exp_res_q[$];
  logic [7:0] stub_cand_q[$];
  iss_t       mon_iss;
  res_t       mon_res;
  logic [7:0] stub_c;

  int total = 0, bad = 0;
  int cyc = 0, en_count = 0, rv_rise_count = 0;
  int last_en_cyc = 0, first_rv_cyc = 0, hs_cyc = 0, gap_last = 0;
  bit prev_rv = 1'b0;
  int stub_lat = 66;
  bit stub_mute = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_stats(input string name, input int jobs, input int tmo);
`ifdef SET_JOB_STATS_EN
    check({name, "_stat_jobs"}, 32'(stat_jobs), 32'(jobs));
    check({name, "_stat_tmo"},  32'(stat_tmo),  32'(tmo));
`else
    check({name, "_stat_jobs"}, 32'(stat_jobs), 32'd0);
    check({name, "_stat_tmo"},  32'(stat_tmo),  32'd0);
`endif
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst && set_en === 1'b1) begin
        en_count++;
        last_en_cyc = cyc;
        gap_last = cyc - hs_cyc;
        if (exp_iss_q.size() == 0) check("set_en_expected", 32'(exp_iss_q.size()), 32'd1);
        else begin
          mon_iss = exp_iss_q.pop_front();
          check("set_central", 32'(set_central), 32'(mon_iss.c));
          check("set_radius",  32'(set_radius),  32'(mon_iss.r));
          check("set_mode",    32'(set_mode),    32'(mon_iss.m));
        end
      end
      if (res_valid === 1'b1 && !prev_rv) begin
        rv_rise_count++;
        first_rv_cyc = cyc;
      end
      prev_rv = (res_valid === 1'b1);
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        hs_cyc = cyc;
        if (exp_res_q.size() == 0) check("result_expected", 32'(exp_res_q.size()), 32'd1);
        else begin
          mon_res = exp_res_q.pop_front();
          check("res_candidate", 32'(res_candidate), 32'(mon_res.cand));
          check("res_tag",       32'(res_tag),       32'(mon_res.tag));
          check("res_err",       32'(res_err),       32'(mon_res.err));
        end
      end
    end
  end

  // SET stub: after each set_en it drives set_valid high for one cycle,
  // stub_lat cycles later.
  initial begin
    set_valid = 1'b0;
    set_candidate = '0;
    forever begin
      @(negedge clk);
      if (set_en === 1'b1 && !stub_mute) begin
        stub_c = (stub_cand_q.size() != 0) ? stub_cand_q.pop_front() : 8'h00;
        repeat (stub_lat) @(posedge clk);
        #1 set_valid = 1'b1;
        set_candidate = stub_c;
        @(posedge clk);
        #1 set_valid = 1'b0;
      end
    end
  end

  // Callers start at posedge+1; the task returns at posedge+1.
  task automatic push(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                      input logic [TAG_W-1:0] t, input logic [7:0] cand, input bit tmo,
                      output bit acc);
    cmd_valid = 1'b1; cmd_central = c; cmd_radius = r; cmd_mode = m; cmd_tag = t;
    @(negedge clk);
    acc = cmd_ready;
    if (acc) begin
      exp_iss_q.push_back('{c, r, m});
      exp_res_q.push_back('{tmo ? 8'h00 : cand, t, tmo});
      if (!tmo) stub_cand_q.push_back(cand);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while ((exp_res_q.size() != 0 || exp_iss_q.size() != 0) && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_drained"}, 32'(exp_res_q.size() + exp_iss_q.size()), 32'd0);
  endtask

  int  en0, rv0, saved_en, n;
  bit  acc, stable;
  logic [7:0]       snap_cand;
  logic [TAG_W-1:0] snap_tag;
  logic             snap_err;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_central = '0; cmd_radius = '0; cmd_mode = '0;
    cmd_tag = '0; set_busy = 1'b0; res_ready = 1'b1;
    wait_cycles(3);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_set_en", 32'(set_en), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_res_candidate", 32'(res_candidate), 32'd0);
    check_stats("rst", 0, 0);
    rst = 1'b0;
    wait_cycles(2);

    // Single job: the stub answers 66 cycles after set_en, and RESP follows one cycle later.
    en0 = en_count;
    push(24'h440000, 12'h300, 2'd0, 4'd3, 8'd29, 1'b0, acc);
    check("t1_accept", 32'(acc), 32'd1);
    wait_drain("t1", 300);
    check("t1_one_set_en", 32'(en_count - en0), 32'd1);
    check("t1_latency", 32'(first_rv_cyc - last_en_cyc), 32'd67);
    check_stats("t1", 1, 0);

    // Busy engine: four commands fill the FIFO, the fifth is refused.
    set_busy = 1'b1;
    en0 = en_count;
    for (int i = 0; i < 5; i++) begin
      push({16'h0010, 8'(i)}, 12'(i * 3 + 1), 2'(i), 4'(i), 8'(8'h20 + i), 1'b0, acc);
      check("t2_accept", 32'(acc), 32'(i < 4));
    end
    check("t2_cmd_ready_full", 32'(cmd_ready), 32'd0);
    check("t2_pending", 32'(pending), 32'd4);
    wait_cycles(5);
    check("t2_no_set_en", 32'(en_count - en0), 32'd0);
    set_busy = 1'b0;
    stub_lat = 5;
    wait_drain("t2", 600);
    check("t2_four_jobs", 32'(en_count - en0), 32'd4);
    check("t2_pending_empty", 32'(pending), 32'd0);

    // Silent engine: 127 WAIT cycles, then RESP, which is 128 cycles after set_en.
    stub_mute = 1'b1;
    push(24'h123456, 12'hABC, 2'd2, 4'd5, 8'h00, 1'b1, acc);
    wait_drain("t3", 400);
    check("t3_latency", 32'(first_rv_cyc - last_en_cyc), 32'd128);
    stub_mute = 1'b0;
    check_stats("t3", 5, 1);

    // Stalled consumer: the result must hold and no second job may issue.
    res_ready = 1'b0;
    stub_lat = 10;
    for (int i = 0; i < 3; i++)
      push({16'h0060, 8'(i)}, 12'h111, 2'd1, 4'(6 + i), 8'(8'h61 + i), 1'b0, acc);
    n = 0;
    while (res_valid !== 1'b1 && n < 100) begin @(posedge clk); n++; end
    #1;
    check("t4_res_valid", 32'(res_valid), 32'd1);
    check("t4_pending", 32'(pending), 32'd2);
    snap_cand = res_candidate; snap_tag = res_tag; snap_err = res_err;
    saved_en = en_count;
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || res_candidate !== snap_cand || res_tag !== snap_tag ||
          res_err !== snap_err)
        stable = 1'b0;
    end
    check("t4_stable", 32'(stable), 32'd1);
    check("t4_no_set_en", 32'(en_count - saved_en), 32'd0);
    res_ready = 1'b1;
    n = 0;
    while (en_count == saved_en && n < 20) begin @(posedge clk); n++; end
    #1;
    check("t4_gap", 32'(gap_last), 32'd2);
    wait_drain("t4", 300);
    check_stats("t4", 8, 1);

    // Reset during WAIT with three jobs still queued.
    stub_lat = 30;
    for (int i = 0; i < 4; i++)
      push({16'h0090, 8'(i)}, 12'h222, 2'd3, 4'(9 + i), 8'(8'h90 + i), 1'b0, acc);
    wait_cycles(5);
    check("t5_pending_before", 32'(pending), 32'd3);
    rst = 1'b1;
    #1;
    check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t5_set_en", 32'(set_en), 32'd0);
    check("t5_res_valid", 32'(res_valid), 32'd0);
    check("t5_pending", 32'(pending), 32'd0);
    check("t5_res_candidate", 32'(res_candidate), 32'd0);
    check("t5_set_central", 32'(set_central), 32'd0);
    check_stats("t5", 0, 0);
    exp_iss_q.delete();
    exp_res_q.delete();
    stub_cand_q.delete();
    wait_cycles(2);
    rst = 1'b0;
    rv0 = rv_rise_count;
    en0 = en_count;
    wait_cycles(50);
    check("t5_no_result", 32'(rv_rise_count - rv0), 32'd0);
    check("t5_no_set_en", 32'(en_count - en0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
